// File: rtl/offnariscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | offnariscv_pkg : shared widths and ROB types (default configuration)  |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package offnariscv_pkg;

   localparam int unsigned RD_W      = 5;
   localparam int unsigned ROB_DEPTH = 8;
   localparam int unsigned ROB_XLEN  = 32;
   localparam int unsigned ROB_TAG_W = $clog2(ROB_DEPTH);

   typedef logic [ROB_TAG_W-1:0] rob_tag_t;
   typedef logic [ROB_TAG_W:0]   rob_ptr_t;

   typedef struct packed {
      logic                valid;
      logic                done;
      logic [RD_W-1:0]     rd;
      logic [ROB_XLEN-1:0] pc;
      logic [ROB_XLEN-1:0] result;
      logic                redirect;
      logic [ROB_XLEN-1:0] new_pc;
      logic                trap;
      logic [ROB_XLEN-1:0] cause;
   } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/rob_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rob_ptr : wrap-bit ring pointer with increment and parallel load      |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module rob_ptr #(
   parameter int unsigned PTR_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             load,
   input  logic [PTR_W-1:0] load_val,
   output logic [PTR_W-1:0] ptr
);

   logic [PTR_W-1:0] ptr_d;
   logic [PTR_W-1:0] ptr_q;

   // The MSB toggles on each pass, so plain binary overflow is the wrap.
   always_comb begin
      ptr_d = ptr_q;
      if (load) begin
         ptr_d = load_val;
      end else if (inc) begin
         ptr_d = ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/rob_committer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rob_committer : reorder buffer, out-of-order completion, in-order     |
// | single-wide retirement with flush on redirect/trap.  Rev 1.0           |
// +----------------------------------------------------------------------+
module rob_committer
   import offnariscv_pkg::*;
#(
   parameter  int unsigned DEPTH  = ROB_DEPTH,
   parameter  int unsigned NUM_FU = 4,
   parameter  int unsigned XLEN   = ROB_XLEN,
   localparam int unsigned TAG_W  = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     disp_valid,
   output logic                     disp_ready,
   input  logic [RD_W-1:0]          disp_rd,
   input  logic [XLEN-1:0]          disp_pc,
   output logic [TAG_W-1:0]         disp_tag,
   input  logic [NUM_FU-1:0]        comp_valid,
   input  logic [NUM_FU*TAG_W-1:0]  comp_tag,
   input  logic [NUM_FU*XLEN-1:0]   comp_result,
   input  logic [NUM_FU-1:0]        comp_redirect,
   input  logic [NUM_FU*XLEN-1:0]   comp_new_pc,
   input  logic [NUM_FU-1:0]        comp_trap,
   input  logic [NUM_FU*XLEN-1:0]   comp_cause,
   output logic                     rf_valid,
   input  logic                     rf_ready,
   output logic [RD_W-1:0]          rf_rd,
   output logic [XLEN-1:0]          rf_wdata,
   output logic                     pcg_valid,
   input  logic                     pcg_ready,
   output logic [XLEN-1:0]          pcg_pc,
   output logic                     trap_valid,
   output logic [XLEN-1:0]          trap_pc,
   output logic [XLEN-1:0]          trap_cause,
   output logic                     flush,
   output logic [TAG_W:0]           occupancy
);

   typedef logic [TAG_W-1:0] tag_t;
   typedef logic [TAG_W:0]   ptr_t;

   typedef struct packed {
      logic            valid;
      logic            done;
      logic [RD_W-1:0] rd;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] result;
      logic            redirect;
      logic [XLEN-1:0] new_pc;
      logic            trap;
      logic [XLEN-1:0] cause;
   } entry_t;

   entry_t entry_q [DEPTH];
   entry_t entry_d [DEPTH];

   ptr_t   head;
   ptr_t   tail;
   ptr_t   tail_flush;
   tag_t   head_idx;
   tag_t   tail_idx;
   entry_t head_e;
   logic   full;
   logic   fire;
   logic   commit_redirect;
   logic   disp_fire;
   logic   dup_tag;

   assign head_idx = head[TAG_W-1:0];
   assign tail_idx = tail[TAG_W-1:0];
   assign head_e   = entry_q[head_idx];
   assign full     = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);

   assign fire = !rst && head_e.valid && head_e.done && rf_ready &&
                 (!(head_e.redirect || head_e.trap) || pcg_ready);
   assign commit_redirect = fire && (head_e.redirect || head_e.trap);
   assign disp_ready      = !rst && !full && !commit_redirect;
   assign disp_fire       = disp_valid && disp_ready;

   // A redirect leaves the ROB empty just past the retiring entry.
   assign tail_flush = head + ptr_t'(1);

   rob_ptr #(.PTR_W(TAG_W + 1)) u_head (
      .clk      (clk),
      .rst      (rst),
      .inc      (fire),
      .load     (1'b0),
      .load_val ('0),
      .ptr      (head)
   );

   rob_ptr #(.PTR_W(TAG_W + 1)) u_tail (
      .clk      (clk),
      .rst      (rst),
      .inc      (disp_fire),
      .load     (commit_redirect),
      .load_val (tail_flush),
      .ptr      (tail)
   );

   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         entry_d[i] = entry_q[i];
      end
      if (disp_fire) begin
         entry_d[tail_idx]       = '0;
         entry_d[tail_idx].valid = 1'b1;
         entry_d[tail_idx].rd    = disp_rd;
         entry_d[tail_idx].pc    = disp_pc;
      end
      // Completions against freed slots are stale and dropped.
      for (int unsigned k = 0; k < NUM_FU; k++) begin
         if (comp_valid[k] && entry_q[comp_tag[k*TAG_W +: TAG_W]].valid) begin
            entry_d[comp_tag[k*TAG_W +: TAG_W]].done     = 1'b1;
            entry_d[comp_tag[k*TAG_W +: TAG_W]].result   = comp_result[k*XLEN +: XLEN];
            entry_d[comp_tag[k*TAG_W +: TAG_W]].redirect = comp_redirect[k];
            entry_d[comp_tag[k*TAG_W +: TAG_W]].new_pc   = comp_new_pc[k*XLEN +: XLEN];
            entry_d[comp_tag[k*TAG_W +: TAG_W]].trap     = comp_trap[k];
            entry_d[comp_tag[k*TAG_W +: TAG_W]].cause    = comp_cause[k*XLEN +: XLEN];
         end
      end
      if (fire) begin
         entry_d[head_idx].valid = 1'b0;
      end
      if (commit_redirect) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_d[i].valid = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (rst) begin
            entry_q[i] <= '0;
         end else begin
            entry_q[i] <= entry_d[i];
         end
      end
   end

   always_comb begin
      dup_tag = 1'b0;
      for (int unsigned a = 0; a < NUM_FU; a++) begin
         for (int unsigned b = a + 1; b < NUM_FU; b++) begin
            if (comp_valid[a] && comp_valid[b] &&
                (comp_tag[a*TAG_W +: TAG_W] == comp_tag[b*TAG_W +: TAG_W])) begin
               dup_tag = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!dup_tag);
      end
   end

   assign rf_valid   = fire;
   assign rf_rd      = head_e.trap ? '0 : head_e.rd;
   assign rf_wdata   = head_e.result;
   assign pcg_valid  = commit_redirect;
   assign pcg_pc     = head_e.new_pc;
   assign trap_valid = fire && head_e.trap;
   assign trap_pc    = head_e.pc;
   assign trap_cause = head_e.cause;
   assign flush      = commit_redirect;
   assign occupancy  = rst ? '0 : (tail - head);
   assign disp_tag   = tail_idx;

endmodule
`default_nettype wire
